// File: rtl/stable_matching_pkg.sv
// ============================================================================
// stable_matching_pkg : widths, FSM encoding and p_input packing helpers
// Revision 1.0
// ============================================================================
`default_nettype none

package stable_matching_pkg;

    // Ceiling log2, never below 1 so single-entry ranges still get a bit.
    function automatic int clog2f(input int v);
        int w;
        w = 1;
        while ((1 << w) < v) w++;
        return w;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SCAN    = 3'd2,
        ST_PROPOSE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    function automatic int a_bit(input int s, input int k, input int ks, input int logr);
        return (s * ks + k) * logr;
    endfunction

    function automatic int b_bit(input int r, input int k, input int s_n, input int ks,
                                 input int kr, input int logr, input int logs);
        return s_n * ks * logr + (r * kr + k) * logs;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sm_rank_lookup.sv
// ============================================================================
// sm_rank_lookup : position of a proposer within one receiver's preference list
// Revision 1.0
// ============================================================================
`default_nettype none

module sm_rank_lookup
    import stable_matching_pkg::*;
#(
    parameter  int Kr   = 12,
    parameter  int S    = 16,
    parameter  int logS = clog2f(S),
    localparam int RKW  = clog2f(Kr) + 1
) (
    input  logic [Kr*logS-1:0] i_prefs,
    input  logic [logS-1:0]    i_id,
    output logic               o_hit,
    output logic [RKW-1:0]     o_rank
);

    logic [Kr-1:0] w_eq;

    generate
        for (genvar k = 0; k < Kr; k++) begin : g_cmp
            assign w_eq[k] = (i_prefs[k*logS +: logS] == i_id);
        end
    endgenerate

    // Descending scan so the first occurrence of a duplicate entry wins.
    always_comb begin
        o_hit  = |w_eq;
        o_rank = '0;
        for (int k = Kr - 1; k >= 0; k--) begin
            if (w_eq[k]) o_rank = RKW'(k);
        end
    end

endmodule

`default_nettype wire

// File: rtl/stable_matching_seq_ctrl.sv
// ============================================================================
// stable_matching_seq_ctrl : sequential Gale-Shapley engine, one proposal per SCAN/PROPOSE pair
// Revision 1.0
// ============================================================================
`default_nettype none

module stable_matching_seq_ctrl
    import stable_matching_pkg::*;
#(
    parameter  int S    = 16,
    parameter  int R    = S,
    parameter  int Ks   = 12,
    parameter  int Kr   = Ks,
    localparam int logS = clog2f(S),
    localparam int logR = clog2f(R),
    localparam int CW   = clog2f(S * Ks + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [S*Ks*logR+R*Kr*logS-1:0]       p_input,
    output logic                                 busy,
    output logic                                 done,
    output logic [R*logS-1:0]                    o,
    output logic [R-1:0]                         o_matched,
    output logic [CW-1:0]                        n_prop
);

    localparam int PW  = clog2f(Ks + 1);
    localparam int KIW = clog2f(Ks);
    localparam int RKW = clog2f(Kr) + 1;
    localparam logic [PW-1:0] c_ks    = PW'(Ks);
    localparam logic [logR:0] c_r_lim = (logR + 1)'(R);

    state_t             r_state;
    logic [logS-1:0]    r_cur;
    logic [PW-1:0]      r_ptr    [S];
    logic [S-1:0]       r_free;
    logic [logS-1:0]    r_holder [R];
    logic [RKW-1:0]     r_hrank  [R];
    logic [R-1:0]       r_matched;
    logic [CW-1:0]      r_nprop;
    logic               r_busy;
    logic               r_done;
    logic [logR-1:0]    r_pref_a [S][Ks];
    logic [logS-1:0]    r_pref_b [R][Kr];

    logic               w_accept;
    logic               w_found;
    logic [logS-1:0]    w_sel;
    logic [PW-1:0]      w_ptr_cur;
    logic [logR-1:0]    w_r;
    logic               w_r_ok;
    logic [logR-1:0]    w_r_idx;
    logic [Kr*logS-1:0] w_b_row;
    logic               w_hit;
    logic [RKW-1:0]     w_rank;

    assign w_accept  = start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_ptr_cur = r_ptr[r_cur];
    assign w_r       = r_pref_a[r_cur][w_ptr_cur[KIW-1:0]];
    assign w_r_ok    = ({1'b0, w_r} < c_r_lim);
    assign w_r_idx   = w_r_ok ? w_r : '0;

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int s = S - 1; s >= 0; s--) begin
            if (r_free[s] && (r_ptr[s] < c_ks)) begin
                w_found = 1'b1;
                w_sel   = logS'(s);
            end
        end
    end

    always_comb begin
        w_b_row = '0;
        for (int k = 0; k < Kr; k++) begin
            w_b_row[k*logS +: logS] = r_pref_b[w_r_idx][k];
        end
    end

    sm_rank_lookup #(
        .Kr   (Kr),
        .S    (S),
        .logS (logS)
    ) u_rank (
        .i_prefs (w_b_row),
        .i_id    (r_cur),
        .o_hit   (w_hit),
        .o_rank  (w_rank)
    );

    // Preference stores are pure data; they are only meaningful after a start.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int s = 0; s < S; s++)
                for (int k = 0; k < Ks; k++)
                    r_pref_a[s][k] <= p_input[a_bit(s, k, Ks, logR) +: logR];
            for (int r = 0; r < R; r++)
                for (int k = 0; k < Kr; k++)
                    r_pref_b[r][k] <= p_input[b_bit(r, k, S, Ks, Kr, logR, logS) +: logS];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cur     <= '0;
            r_free    <= '0;
            r_matched <= '0;
            r_nprop   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            for (int s = 0; s < S; s++) r_ptr[s] <= '0;
            for (int r = 0; r < R; r++) begin
                r_holder[r] <= '0;
                r_hrank[r]  <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state <= ST_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_free    <= '1;
                    r_matched <= '0;
                    r_nprop   <= '0;
                    for (int s = 0; s < S; s++) r_ptr[s] <= '0;
                    for (int r = 0; r < R; r++) begin
                        r_holder[r] <= '0;
                        r_hrank[r]  <= '0;
                    end
                    r_state <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (w_found) begin
                        r_cur   <= w_sel;
                        r_state <= ST_PROPOSE;
                    end else begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_PROPOSE: begin
                    r_ptr[r_cur] <= w_ptr_cur + PW'(1);
                    r_nprop      <= r_nprop + CW'(1);
                    // A displaced holder keeps its pointer and resumes from its next choice.
                    if (w_r_ok && w_hit &&
                        (!r_matched[w_r_idx] || (w_rank < r_hrank[w_r_idx]))) begin
                        if (r_matched[w_r_idx]) r_free[r_holder[w_r_idx]] <= 1'b1;
                        r_holder[w_r_idx]  <= r_cur;
                        r_hrank[w_r_idx]   <= w_rank;
                        r_matched[w_r_idx] <= 1'b1;
                        r_free[r_cur]      <= 1'b0;
                    end
                    r_state <= ST_SCAN;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    generate
        for (genvar r = 0; r < R; r++) begin : g_out
            assign o[r*logS +: logS] = r_holder[r];
        end
    endgenerate

    assign busy      = r_busy;
    assign done      = r_done;
    assign o_matched = r_matched;
    assign n_prop    = r_nprop;

endmodule

`default_nettype wire

// File: tb/tb_stable_matching_seq_ctrl.sv
// ============================================================================
// tb_stable_matching_seq_ctrl : scoreboard bench against a behavioural Gale-Shapley model
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_stable_matching_seq_ctrl;

    localparam int S    = 16;
    localparam int R    = 16;
    localparam int Ks   = 12;
    localparam int Kr   = 12;
    localparam int logS = 4;
    localparam int logR = 4;
    localparam int CW   = 8;
    localparam int PIW  = S*Ks*logR + R*Kr*logS;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [PIW-1:0]   p_input = '0;
    logic             busy;
    logic             done;
    logic [R*logS-1:0] o;
    logic [R-1:0]     o_matched;
    logic [CW-1:0]    n_prop;

    stable_matching_seq_ctrl #(.S(S), .R(R), .Ks(Ks), .Kr(Kr)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .p_input   (p_input),
        .busy      (busy),
        .done      (done),
        .o         (o),
        .o_matched (o_matched),
        .n_prop    (n_prop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [63:0] o;
        logic [15:0] m;
        int          np;
        int          due;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;

    logic [logR-1:0] pa [S][Ks];
    logic [logS-1:0] pb [R][Kr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int rank_of(input int r, input int s);
        for (int k = 0; k < Kr; k++)
            if (int'(pb[r][k]) == s) return k;
        return -1;
    endfunction

    // Proposers in turn, lowest free index first; each receiver keeps its best offer so far.
    task automatic gs_model(output exp_t e);
        int ptr [S];
        bit fr  [S];
        int hold[R];
        bit hm  [R];
        int s, r, rk;
        for (int i = 0; i < S; i++) begin ptr[i] = 0; fr[i] = 1'b1; end
        for (int i = 0; i < R; i++) begin hold[i] = 0; hm[i] = 1'b0; end
        e.np  = 0;
        e.due = 0;
        forever begin
            s = -1;
            for (int i = 0; i < S; i++)
                if (fr[i] && ptr[i] < Ks) begin s = i; break; end
            if (s < 0) break;
            r = int'(pa[s][ptr[s]]);
            ptr[s]++;
            e.np++;
            rk = (r < R) ? rank_of(r, s) : -1;
            if (rk < 0) continue;
            if (!hm[r]) begin
                hold[r] = s; hm[r] = 1'b1; fr[s] = 1'b0;
            end else if (rk < rank_of(r, hold[r])) begin
                fr[hold[r]] = 1'b1; hold[r] = s; fr[s] = 1'b0;
            end
        end
        e.o = '0;
        e.m = '0;
        for (int i = 0; i < R; i++) begin
            e.o[i*logS +: logS] = hold[i][logS-1:0];
            e.m[i] = hm[i];
        end
    endtask

    task automatic pack_inputs(output logic [PIW-1:0] v);
        v = '0;
        for (int s = 0; s < S; s++)
            for (int k = 0; k < Ks; k++)
                v[(s*Ks + k)*logR +: logR] = pa[s][k];
        for (int r = 0; r < R; r++)
            for (int k = 0; k < Kr; k++)
                v[S*Ks*logR + (r*Kr + k)*logS +: logS] = pb[r][k];
    endtask

    task automatic issue_start(input bit expect_accept);
        logic [PIW-1:0] v;
        exp_t e;
        pack_inputs(v);
        @(posedge clk); #1;
        p_input = v;
        start   = 1'b1;
        if (expect_accept) begin
            gs_model(e);
            e.due = cyc + 3 + 2*e.np;
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (done) return;
        end
        check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic set_random(input bit omit_p0);
        for (int s = 0; s < S; s++)
            for (int k = 0; k < Ks; k++)
                pa[s][k] = logR'($urandom_range(R-1, 0));
        for (int r = 0; r < R; r++)
            for (int k = 0; k < Kr; k++)
                pb[r][k] = logS'(omit_p0 ? $urandom_range(S-1, 1) : $urandom_range(S-1, 0));
    endtask

    task automatic set_identity();
        for (int s = 0; s < S; s++)
            for (int k = 0; k < Ks; k++) pa[s][k] = logR'((s + k) % R);
        for (int r = 0; r < R; r++)
            for (int k = 0; k < Kr; k++) pb[r][k] = logS'((r + k) % S);
    endtask

    // Proposers 0/1 and receivers 0/1 replay the two-by-two displacement case; the rest pair off directly.
    task automatic set_case1();
        set_identity();
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < Ks; k++) pa[s][k] = logR'(k % R);
        for (int k = 0; k < Kr; k++) begin
            pb[0][k] = logS'((k == 0) ? 1 : (k == 1) ? 0 : k);
            pb[1][k] = logS'(k % S);
        end
    endtask

    task automatic check_case1();
        logic [63:0] exp_o;
        for (int r = 0; r < R; r++) exp_o[r*logS +: logS] = logS'(r);
        exp_o[3:0] = 4'd1;
        exp_o[7:4] = 4'd0;
        check("case1_o", o, exp_o);
        check("case1_matched", 64'(o_matched), 64'hffff);
        check("case1_nprop", 64'(n_prop), 64'd17);
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sbq.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("o", o, e.o);
                check("o_matched", 64'(o_matched), 64'(e.m));
                check("n_prop", 64'(n_prop), 64'(e.np));
                check("done_cycle", 64'(cyc), 64'(e.due));
                check("busy_at_done", 64'(busy), 64'd0);
                check("n_prop_bound", 64'(n_prop <= 8'd192), 64'd1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] id_o;
        logic        p0_held;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_o", o, 64'd0);
        check("rst_matched", 64'(o_matched), 64'd0);
        check("rst_nprop", 64'(n_prop), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        set_identity();
        issue_start(1'b1);
        wait_done();
        for (int r = 0; r < R; r++) id_o[r*logS +: logS] = logS'(r);
        check("ident_o", o, id_o);
        check("ident_nprop", 64'(n_prop), 64'd16);

        set_case1();
        issue_start(1'b1);
        wait_done();
        check_case1();

        // Reset lands in PROPOSE after two proposals have already updated the partial matching.
        issue_start(1'b1);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sbq.delete();
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_o", o, 64'd0);
        check("midrst_matched", 64'(o_matched), 64'd0);
        check("midrst_nprop", 64'(n_prop), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue_start(1'b1);
        wait_done();
        check_case1();

        set_random(1'b0);
        issue_start(1'b1);
        set_random(1'b0);
        issue_start(1'b0);
        wait_done();
        set_random(1'b0);
        issue_start(1'b1);
        wait_done();

        for (int t = 0; t < 2; t++) begin
            set_random(1'b1);
            issue_start(1'b1);
            wait_done();
            p0_held = 1'b0;
            for (int r = 0; r < R; r++)
                if (o_matched[r] && o[r*logS +: logS] == 4'd0) p0_held = 1'b1;
            check("omit_p0", 64'(p0_held), 64'd0);
        end

        for (int t = 0; t < 15; t++) begin
            set_random(1'b0);
            issue_start(1'b1);
            wait_done();
        end

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 64'(sbq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
